sram_ctrl: RTL



---
 rtl/sram_ctrl_pkg.sv | 20 ++
 rtl/sram_pulse_timer.sv | 34 +++
 rtl/sram_ctrl.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/sram_ctrl_pkg.sv
// Shared types for the SRAM macro sequencer: FSM state encoding and request opcode.
package sram_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD,
        RD_PRE,
        RD_PULSE,
        RD_SAMPLE,
        ERR
    } state_e;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_e;

endpackage

// File: rtl/sram_pulse_timer.sv
// Loadable down-counter that times the row strobe; done is high while the count is zero.
module sram_pulse_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             done
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == '0);

endmodule

// File: rtl/sram_ctrl.sv
// Sequencer for the SRAM macro: turns one read/write request into timed precharge,
// write-driver, row-strobe and sense-amp enables, all driven from registers.
module sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int ROWS   = 2,
    parameter int COLS   = 8,
    parameter int WR_CYC = 10,
    parameter int RD_CYC = 10,
    parameter int AW     = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req,
    output logic            ready,
    input  logic            we,
    input  logic [AW-1:0]   addr,
    input  logic [COLS-1:0] wdata,
    output logic [COLS-1:0] rdata,
    output logic            rvalid,
    output logic            err,
    output logic            drv_en,
    output logic [COLS-1:0] drv_data,
    output logic [ROWS-1:0] row_wr_en,
    output logic [ROWS-1:0] row_rd_en,
    output logic            pre_en,
    output logic            sa_en,
    input  logic [COLS-1:0] sa_out
);

    localparam int MAX_CYC = (WR_CYC > RD_CYC) ? WR_CYC : RD_CYC;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    state_e state_q, state_d;
    op_e    op_in;
    logic [AW-1:0]    addr_q, addr_d;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic             tmr_done;
    logic [ROWS-1:0]  row_sel;

    logic            ready_q, ready_d;
    logic            rvalid_q, rvalid_d;
    logic            err_q, err_d;
    logic            drv_en_q, drv_en_d;
    logic            pre_en_q, pre_en_d;
    logic            sa_en_q, sa_en_d;
    logic [COLS-1:0] rdata_q, rdata_d;
    logic [COLS-1:0] drv_data_q, drv_data_d;
    logic [ROWS-1:0] row_wr_en_q, row_wr_en_d;
    logic [ROWS-1:0] row_rd_en_q, row_rd_en_d;

    assign op_in = we ? OP_WR : OP_RD;

    sram_pulse_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // The timer is loaded with N-1 on the cycle before the pulse so the pulse lasts N clocks.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        unique case (state_q)
            IDLE: begin
                if (req && ready_q) begin
                    addr_d = addr;
                    if (32'(addr) >= 32'(ROWS)) begin
                        state_d = ERR;
                    end else if (op_in == OP_WR) begin
                        state_d = WR_SETUP;
                    end else begin
                        state_d = RD_PRE;
                    end
                end
            end
            WR_SETUP: begin
                state_d  = WR_PULSE;
                tmr_load = 1'b1;
                tmr_val  = CNT_W'(WR_CYC - 1);
            end
            WR_PULSE:  if (tmr_done) state_d = WR_HOLD;
            WR_HOLD:   state_d = IDLE;
            RD_PRE: begin
                state_d  = RD_PULSE;
                tmr_load = 1'b1;
                tmr_val  = CNT_W'(RD_CYC - 1);
            end
            RD_PULSE:  if (tmr_done) state_d = RD_SAMPLE;
            RD_SAMPLE: state_d = IDLE;
            ERR:       state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so every enable comes straight off a flop.
    always_comb begin
        row_sel     = ROWS'(1) << addr_d;
        ready_d     = (state_d == IDLE);
        drv_en_d    = (state_d == WR_SETUP) || (state_d == WR_PULSE) || (state_d == WR_HOLD);
        row_wr_en_d = (state_d == WR_PULSE) ? row_sel : '0;
        row_rd_en_d = ((state_d == RD_PULSE) || (state_d == RD_SAMPLE)) ? row_sel : '0;
        pre_en_d    = (state_d == RD_PRE);
        sa_en_d     = (state_d == RD_SAMPLE);
        err_d       = (state_d == ERR);
        rvalid_d    = (state_q == RD_SAMPLE);
        rdata_d     = (state_q == RD_SAMPLE) ? sa_out : rdata_q;
        drv_data_d  = ((state_q == IDLE) && (state_d == WR_SETUP)) ? wdata : drv_data_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ready_q     <= 1'b1;
            rvalid_q    <= 1'b0;
            err_q       <= 1'b0;
            drv_en_q    <= 1'b0;
            pre_en_q    <= 1'b0;
            sa_en_q     <= 1'b0;
            rdata_q     <= '0;
            drv_data_q  <= '0;
            row_wr_en_q <= '0;
            row_rd_en_q <= '0;
        end else begin
            ready_q     <= ready_d;
            rvalid_q    <= rvalid_d;
            err_q       <= err_d;
            drv_en_q    <= drv_en_d;
            pre_en_q    <= pre_en_d;
            sa_en_q     <= sa_en_d;
            rdata_q     <= rdata_d;
            drv_data_q  <= drv_data_d;
            row_wr_en_q <= row_wr_en_d;
            row_rd_en_q <= row_rd_en_d;
        end
    end

    always_ff @(posedge clk) begin
        addr_q <= addr_d;
    end

    assign ready     = ready_q;
    assign rvalid    = rvalid_q;
    assign err       = err_q;
    assign drv_en    = drv_en_q;
    assign drv_data  = drv_data_q;
    assign row_wr_en = row_wr_en_q;
    assign row_rd_en = row_rd_en_q;
    assign pre_en    = pre_en_q;
    assign sa_en     = sa_en_q;
    assign rdata     = rdata_q;

endmodule
